// File: rtl/pwm_duty_ctrl_pkg.sv
// Shared types, constants and level arithmetic for the PWM duty controller.
// Package pwm_pkg: LEVEL_MAX / STEPS / LEVEL_W, level_t and the saturating
// level update used by the button logic.
package pwm_pkg;

  localparam int unsigned LEVEL_W   = 4;
  localparam int unsigned LEVEL_MAX = 10;
  localparam int unsigned STEPS     = 10;

  typedef logic [LEVEL_W-1:0] level_t;

  // Saturating 0..LEVEL_MAX update; simultaneous up and down cancel out.
  function automatic level_t next_level(level_t lvl, logic up, logic dn);
    level_t nxt;
    nxt = lvl;
    if (up && !dn && (lvl < level_t'(LEVEL_MAX))) begin
      nxt = lvl + level_t'(1);
    end else if (dn && !up && (lvl != level_t'(0))) begin
      nxt = lvl - level_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Button / PWM / display bundle of the PWM duty controller.
//   btn_up, btn_dn      : raw asynchronous active-high buttons
//   PWM_OUT             : registered PWM waveform
//   digit0..digit2      : duty level code 0..10, identical on all three
// master = stimulus/button side, slave = controller side.
interface pwm_duty_ctrl_if;
  import pwm_pkg::*;

  logic   btn_up;
  logic   btn_dn;
  logic   PWM_OUT;
  level_t digit0;
  level_t digit1;
  level_t digit2;

  modport master (
    output btn_up,
    output btn_dn,
    input  PWM_OUT,
    input  digit0,
    input  digit1,
    input  digit2
  );

  modport slave (
    input  btn_up,
    input  btn_dn,
    output PWM_OUT,
    output digit0,
    output digit1,
    output digit2
  );

endinterface

// File: rtl/pwm_duty_ctrl_debounce.sv
// btn_debounce: level filter for an already synchronized button.
// Only built when PWM_DUTY_DEBOUNCE_EN is defined.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   din      : synchronized button level
//   dout     : filtered level, follows din after DEB_CYCLES equal samples
`ifdef PWM_DUTY_DEBOUNCE_EN
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: two-button duty selector (0..10 = 0..100 %) driving a
// 10-step PWM and a 3-digit level display.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pwm_duty_ctrl_if.slave (btn_up, btn_dn, PWM_OUT, digit0..2)
// Parameters: CLK_DIV clk cycles per PWM step, DEB_CYCLES debounce length.
// Optional: PWM_DUTY_DEBOUNCE_EN inserts btn_debounce after each synchronizer.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DEB_CYCLES = 8
) (
  input logic            clk,
  input logic            rst,
  pwm_duty_ctrl_if.slave bus
);

  localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if ((CLK_DIV < 1) || (DEB_CYCLES < 1)) begin : g_param_chk
    $error("pwm_duty_ctrl: CLK_DIV and DEB_CYCLES must be >= 1");
  end

  logic [1:0]         up_sync;
  logic [1:0]         dn_sync;
  logic               up_cond;
  logic               dn_cond;
  logic               up_q;
  logic               dn_q;
  logic               up_ev_c;
  logic               dn_ev_c;
  level_t             lvl;
  level_t             act;
  level_t             step;
  logic [PRESC_W-1:0] presc;
  logic               tick_c;
  logic               wrap_c;
  logic               pwm;

  // Two-flop synchronizers for the asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[0], bus.btn_up};
      dn_sync <= {dn_sync[0], bus.btn_dn};
    end
  end

`ifdef PWM_DUTY_DEBOUNCE_EN
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk  (clk),
    .rst  (rst),
    .din  (up_sync[1]),
    .dout (up_cond)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk  (clk),
    .rst  (rst),
    .din  (dn_sync[1]),
    .dout (dn_cond)
  );
`else
  assign up_cond = up_sync[1];
  assign dn_cond = dn_sync[1];
`endif

  // Rising-edge detect: one event per press regardless of hold time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q <= 1'b0;
      dn_q <= 1'b0;
    end else begin
      up_q <= up_cond;
      dn_q <= dn_cond;
    end
  end

  always_comb begin
    up_ev_c = up_cond & ~up_q;
    dn_ev_c = dn_cond & ~dn_q;
  end

  // Requested level; also drives the display directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl <= '0;
    end else if (up_ev_c || dn_ev_c) begin
      lvl <= next_level(lvl, up_ev_c, dn_ev_c);
    end
  end

  // Prescaler: one tick every CLK_DIV cycles.
  always_comb begin
    tick_c = (presc == PRESC_W'(CLK_DIV - 1));
    wrap_c = tick_c && (step == level_t'(STEPS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Step counter 0..STEPS-1; act only reloads at the period boundary so a
  // mid-period level change never distorts the running period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= '0;
      act  <= '0;
    end else if (wrap_c) begin
      step <= '0;
      act  <= lvl;
    end else if (tick_c) begin
      step <= step + level_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (step < act);
    end
  end

  assign bus.PWM_OUT = pwm;
  assign bus.digit0  = lvl;
  assign bus.digit1  = lvl;
  assign bus.digit2  = lvl;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl (CLK_DIV=4, DEB_CYCLES=8).
// Works with or without PWM_DUTY_DEBOUNCE_EN; only the bounce expectation
// differs. cyc counts rising edges since the last reset release, so the
// PWM period boundaries sit at multiples of 40.
module tb_pwm_duty_ctrl;
  import pwm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  pwm_duty_ctrl_if bus ();

  pwm_duty_ctrl #(
    .CLK_DIV    (4),
    .DEB_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_digits(input string tag, input int exp);
    check({tag, "_d0"}, 32'(bus.digit0), 32'(exp));
    check({tag, "_d1"}, 32'(bus.digit1), 32'(exp));
    check({tag, "_d2"}, 32'(bus.digit2), 32'(exp));
  endtask

  // Advance one edge and settle just after it.
  task automatic step1();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step1();
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step1();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic press(input logic up, input logic dn);
    bus.btn_up = up;
    bus.btn_dn = dn;
    run(20);
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    run(20);
  endtask

  // High-cycle count over the full period after the next boundary.
  task automatic measure(output int highs);
    wait_to((cyc / 40 + 1) * 40);
    highs = 0;
    repeat (40) begin
      step1();
      highs += int'(bus.PWM_OUT);
    end
  endtask

  initial begin
    int highs;
    int ha;
    int hb;
    int b;
    int d;

    rst        = 1'b1;
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    run(2);
    check("rst_pwm", 32'(bus.PWM_OUT), 32'd0);
    check_digits("rst", 0);
    rst = 1'b0;
    cyc = 0;
    run(50);
    check("idle_pwm", 32'(bus.PWM_OUT), 32'd0);
    check_digits("idle", 0);

    // Three presses: level 3, 12 of 40 high.
    repeat (3) press(1'b1, 1'b0);
    check_digits("three_up", 3);
    measure(highs);
    check("three_up_highs", 32'(highs), 32'd12);

    // Saturation at 10 and at 0.
    do_reset();
    repeat (12) press(1'b1, 1'b0);
    check_digits("sat_hi", 10);
    measure(highs);
    check("sat_hi_highs", 32'(highs), 32'd40);
    repeat (11) press(1'b0, 1'b1);
    check_digits("sat_lo", 0);
    measure(highs);
    check("sat_lo_highs", 32'(highs), 32'd0);

    // Simultaneous up and down cancel.
    do_reset();
    repeat (5) press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check_digits("both", 5);

    // Mid-period press: current period keeps act=5, next uses 6.
    b = (cyc / 40 + 1) * 40;
    wait_to(b);
    ha = 0;
    hb = 0;
    for (int i = 1; i <= 80; i++) begin
      step1();
      if (i <= 40) ha += int'(bus.PWM_OUT);
      else         hb += int'(bus.PWM_OUT);
      if (i == 4)  bus.btn_up = 1'b1;
      if (i == 24) bus.btn_up = 1'b0;
    end
    check("mid_cur_highs", 32'(ha), 32'd20);
    check("mid_next_highs", 32'(hb), 32'd24);
    check_digits("mid", 6);

    // Asynchronous reset mid-period at level 7.
    press(1'b1, 1'b0);
    check_digits("pre_rst", 7);
    wait_to((cyc / 40 + 1) * 40);
    run(5);
    check("pre_rst_pwm", 32'(bus.PWM_OUT), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_pwm", 32'(bus.PWM_OUT), 32'd0);
    check_digits("async_rst", 0);
    run(2);
    rst = 1'b0;
    cyc = 0;
    bus.btn_up = 1'b1;
    run(20);
    bus.btn_up = 1'b0;
    wait_to(40);
    check("restart_n40", 32'(bus.PWM_OUT), 32'd0);
    step1();
    check("restart_n41", 32'(bus.PWM_OUT), 32'd1);
    run(3);
    check("restart_n44", 32'(bus.PWM_OUT), 32'd1);
    step1();
    check("restart_n45", 32'(bus.PWM_OUT), 32'd0);
    check_digits("restart", 1);

    // Button held through reset release yields exactly one event.
    bus.btn_up = 1'b1;
    do_reset();
    run(30);
    check_digits("held_rst", 1);
    bus.btn_up = 1'b0;
    run(30);
    check_digits("held_rel", 1);

    // Bounced press: 10 segments of 3 cycles, then steady high.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.btn_up = (i % 2 == 0);
      run(3);
    end
    bus.btn_up = 1'b1;
    run(30);
    bus.btn_up = 1'b0;
    run(30);
`ifdef PWM_DUTY_DEBOUNCE_EN
    check_digits("bounce", 1);
`else
    d = int'(bus.digit0);
    check("bounce_range", 32'((d >= 1) && (d <= 10)), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
